// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: decodes format and extended immediate from a
// 32-bit instruction, registered behind a single valid/ready output stage.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  fmt_e            fmt_d;
  logic            ill_d;
  logic [31:0]     imm32;
  logic [5:0]      shamt;
  logic [XLEN-1:0] imm_d;
  logic            accept;

  assign opcode   = in[6:0];
  assign funct3   = in[14:12];
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    fmt_d = FMT_NONE;
    ill_d = 1'b0;
    imm32 = '0;
    shamt = '0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        fmt_d = FMT_I;
        imm32 = {{20{in[31]}}, in[31:20]};
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt_d = FMT_SHAMT;
          // in[25] is the 6th shamt bit on RV64 but out of range on RV32
          if (XLEN == 32 && in[25]) ill_d = 1'b1;
          else if (XLEN == 32)      shamt = {1'b0, in[24:20]};
          else                      shamt = in[25:20];
        end else begin
          fmt_d = FMT_I;
          imm32 = {{20{in[31]}}, in[31:20]};
        end
      end
      OP_STORE: begin
        fmt_d = FMT_S;
        imm32 = {{20{in[31]}}, in[31:25], in[11:7]};
      end
      OP_BR: begin
        fmt_d = FMT_B;
        imm32 = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt_d = FMT_U;
        imm32 = {in[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt_d = FMT_J;
        imm32 = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
      end
      default: ill_d = 1'b1;
    endcase
    imm_d = (fmt_d == FMT_SHAMT) ? XLEN'(shamt) : XLEN'($signed(imm32));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      imm       <= '0;
      fmt       <= FMT_NONE;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      imm       <= imm_d;
      fmt       <= fmt_d;
      illegal   <= ill_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) err_cnt <= '0;
    else if (accept && ill_d && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: RV32 (CNT_W=2) and RV64 instances share
// stimulus; a vector table feeds a scoreboard checked when each result drains.
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  typedef struct {
    int idx;
    int cyc;
    bit lat;
  } sb_t;

  localparam int NV = 10;
  localparam int ADDI = 0, SW = 1, BEQ = 2, LUI = 3, JAL = 4, SRAI = 5,
                 LW = 6, AUIPC = 7, SLLI = 8, ZERO = 9;

  logic        clk = 0;
  logic        reset;
  logic        in_valid, out_ready, cnt_clr;
  logic [31:0] instr;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [1:0]  err32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  err64;

  vec_t tbl [NV];
  sb_t  sbq [$];
  int   ntests = 0, nfail = 0, cyc = 0;

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32), .in(instr),
    .out_valid(ov32), .out_ready(out_ready), .imm(imm32), .fmt(fmt32),
    .illegal(ill32), .err_cnt(err32), .cnt_clr(cnt_clr));

  imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64), .in(instr),
    .out_valid(ov64), .out_ready(out_ready), .imm(imm64), .fmt(fmt64),
    .illegal(ill64), .err_cnt(err64), .cnt_clr(cnt_clr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consume one result per cycle in which the DUT hands it downstream.
  always @(negedge clk) begin : mon
    sb_t  e;
    vec_t v;
    if (!reset && ov32 && out_ready) begin
      if (sbq.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL unexpected_out: got imm %h with empty scoreboard", imm32);
      end else begin
        e = sbq.pop_front();
        v = tbl[e.idx];
        chk($sformatf("imm32[%0d]", e.idx), imm32, v.imm32);
        chk($sformatf("fmt32[%0d]", e.idx), fmt32, v.fmt32);
        chk($sformatf("ill32[%0d]", e.idx), ill32, v.ill32);
        chk($sformatf("ov64[%0d]", e.idx), ov64, 1'b1);
        chk($sformatf("imm64[%0d]", e.idx), imm64, v.imm64);
        chk($sformatf("fmt64[%0d]", e.idx), fmt64, v.fmt64);
        chk($sformatf("ill64[%0d]", e.idx), ill64, v.ill64);
        if (e.lat) chk($sformatf("latency[%0d]", e.idx), cyc, e.cyc);
      end
    end
  end

  task automatic step(input int idx, input bit lat, output bit acc);
    @(negedge clk);
    acc = in_valid && rdy32 && !reset;
    @(posedge clk);
    #1;
    if (acc) sbq.push_back('{idx, cyc, lat});
  endtask

  task automatic send(input int idx, input bit lat);
    bit acc;
    acc = 0;
    instr = tbl[idx].instr;
    in_valid = 1;
    for (int k = 0; k < 20 && !acc; k++) step(idx, lat, acc);
    if (!acc) begin
      ntests++; nfail++;
      $display("FAIL accept_timeout: got no accept expected accept for vector %0d", idx);
    end
  endtask

  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    for (int k = 0; k < 10 && sbq.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", sbq.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; cnt_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    tbl[ADDI]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    tbl[SW]    = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    tbl[BEQ]   = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};
    tbl[LUI]   = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0};
    tbl[JAL]   = '{32'h0010006F, 32'h00000800, 3'd5, 1'b0, 64'h0000000000000800, 3'd5, 1'b0};
    tbl[SRAI]  = '{32'h4030D093, 32'h00000003, 3'd6, 1'b0, 64'h0000000000000003, 3'd6, 1'b0};
    tbl[LW]    = '{32'h00412083, 32'h00000004, 3'd1, 1'b0, 64'h0000000000000004, 3'd1, 1'b0};
    tbl[AUIPC] = '{32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0};
    tbl[SLLI]  = '{32'h02009093, 32'h00000000, 3'd6, 1'b1, 64'h0000000000000020, 3'd6, 1'b0};
    tbl[ZERO]  = '{32'h00000000, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};

    instr = '0; out_ready = 1;
    do_reset();
    chk("rst_ov32", ov32, 0);    chk("rst_imm32", imm32, 0);
    chk("rst_fmt32", fmt32, 0);  chk("rst_ill32", ill32, 0);
    chk("rst_err32", err32, 0);  chk("rst_rdy32", rdy32, 1);
    chk("rst_ov64", ov64, 0);    chk("rst_imm64", imm64, 0);
    chk("rst_err64", err64, 0);  chk("rst_rdy64", rdy64, 1);

    // Back-to-back table run with out_ready held high.
    for (int i = 0; i < NV; i++) send(i, 1);
    drain();
    chk("tbl_err32", err32, 2);
    chk("tbl_err64", err64, 1);

    // Backpressure: addi held for 3 stalled cycles while lui waits.
    out_ready = 1;
    instr = tbl[ADDI].instr; in_valid = 1;
    step(ADDI, 0, acc);
    chk("bp_accept_addi", acc, 1);
    out_ready = 0;
    instr = tbl[LUI].instr;
    for (int k = 0; k < 3; k++) begin
      step(LUI, 1, acc);
      chk("bp_no_accept", acc, 0);
      chk("bp_ov", ov32, 1);
      chk("bp_imm", imm32, 32'hFFFFFFFF);
      chk("bp_rdy", rdy32, 0);
    end
    out_ready = 1;
    step(LUI, 1, acc);
    chk("bp_accept_lui", acc, 1);
    drain();

    // Illegal opcodes saturate the 2-bit counter; clear beats increment.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send(ZERO, 1);
      chk($sformatf("ill_err32_%0d", k), err32, (k > 3) ? 3 : k);
      chk($sformatf("ill_err64_%0d", k), err64, k);
    end
    cnt_clr = 1;
    send(ZERO, 1);
    cnt_clr = 0;
    chk("clr_err32", err32, 0);
    chk("clr_err64", err64, 0);
    drain();

    // shamt 32 is legal only on RV64.
    do_reset();
    send(SLLI, 1);
    drain();
    chk("slli_err32", err32, 1);
    chk("slli_err64", err64, 0);

    // Reset while a result is stalled downstream.
    do_reset();
    out_ready = 0;
    send(ZERO, 0);
    chk("mr_ov_before", ov32, 1);
    chk("mr_err_before", err32, 1);
    instr = tbl[ADDI].instr; in_valid = 1;
    reset = 1;
    step(ADDI, 0, acc);
    chk("mr_ov32", ov32, 0);    chk("mr_imm32", imm32, 0);
    chk("mr_fmt32", fmt32, 0);  chk("mr_ill32", ill32, 0);
    chk("mr_err32", err32, 0);  chk("mr_rdy32", rdy32, 1);
    chk("mr_ov64", ov64, 0);    chk("mr_imm64", imm64, 0);
    sbq.delete();
    reset = 0; in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("mr_ov_after", ov32, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined RV immediate generator for the decode stage. Accepts one 32-bit instruction per cycle over a valid/ready handshake, classifies its format (I, S, B, U, J, shift-immediate), and emits the sign- or zero-extended immediate at XLEN width one cycle later. Flags unsupported opcodes and counts them in a saturating counter. Sits between the fetch/IF-ID register and the ALU operand mux.

## Interface
- XLEN, 32: output immediate width; legal values 32 or 64.
- CNT_W, 8: width of the illegal-instruction counter.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present on `in`.
- in_ready  out  1  block can accept `in` this cycle.
- in  in  32  raw instruction word.
- out_valid  out  1  `imm`/`fmt`/`illegal` hold a result.
- out_ready  in  1  downstream consumes the result this cycle.
- imm  out  XLEN  extended immediate.
- fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- illegal  out  1  opcode not recognised, or shamt out of range.
- err_cnt  out  CNT_W  saturating count of accepted illegal words.
- cnt_clr  in  1  synchronous clear of err_cnt.

## Operation
- Opcode is in[6:0]. In the list below, sext means sign-extension from in[31] to XLEN.
- I (0000011 load, 1100111 jalr, 0010011 arith except shifts): sext(in[31:20]).
- SHAMT (0010011 with funct3 001 or 101): zero-extended shamt.
  - XLEN=32: in[24:20]; in[25]=1 is illegal.
  - XLEN=64: in[25:20].
  - funct7 bits other than in[30] (and in[25] when XLEN=64) are not checked.
- S (0100011): sext({in[31:25], in[11:7]}).
- B (1100011): sext({in[31], in[7], in[30:25], in[11:8], 1'b0}).
- U (0110111 lui, 0010111 auipc): sext({in[31:12], 12'b0}).
- J (1101111): sext({in[31], in[19:12], in[20], in[30:21], 1'b0}).
- Any other opcode: imm=0, fmt=NONE, illegal=1.
- Illegal shamt: imm=0, fmt=SHAMT, illegal=1.
- err_cnt increments by 1 on each accepted word with illegal=1 and saturates at 2^CNT_W-1.
- cnt_clr=1 sets err_cnt to 0. If a clear and an increment occur in the same cycle, the clear wins.

## Timing
- Reset values: out_valid=0, imm=0, fmt=0, illegal=0, err_cnt=0. in_ready=1 in the first cycle after reset.
- Single output register stage; accept-to-out_valid latency is 1 cycle.
- in_ready = !out_valid || out_ready (combinational). This gives full throughput with no bubbles when out_ready is held at 1.
- Accept: in_valid && in_ready at a rising edge. The result registers load and out_valid is set to 1.
- Drain without refill: out_valid && out_ready && !in_valid clears out_valid to 0. imm/fmt/illegal keep their last values.
- Stall: out_valid && !out_ready holds imm/fmt/illegal/out_valid stable. `in` is ignored.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one and out_valid stays 1.
- Reset mid-stream: a pending result is discarded, all outputs return to their reset values, and the cycle's input is not accepted.
- err_cnt updates on the same edge as the accept.

## Test plan
- Reset at XLEN=32, CNT_W=2, out_ready=1:
  - addi 0xFFF00093 → imm 0xFFFFFFFF, fmt 1.
  - sw 0xFE112E23 → 0xFFFFFFFC, fmt 2.
  - beq 0xFE000CE3 → 0xFFFFFFF8, fmt 3.
  - Words driven back-to-back; results appear on consecutive cycles, each 1 cycle after its input.
- Same setup:
  - lui 0x123452B7 → 0x12345000, fmt 4.
  - jal 0x0010006F → 0x00000800, fmt 5.
  - srai 0x4030D093 → 0x00000003, fmt 6, illegal 0.
- Backpressure: accept addi 0xFFF00093, then hold out_ready=0 for 3 cycles while driving lui 0x123452B7.
  - out_valid and imm 0xFFFFFFFF stay stable; in_ready=0.
  - When out_ready rises: imm 0x12345000 on the next cycle.
- Illegal opcode: drive 0x00000000 five times.
  - illegal=1 and imm=0 each time.
  - err_cnt goes 1, 2, 3, 3, 3.
  - cnt_clr with a sixth illegal word in the same cycle → err_cnt 0.
- XLEN=64:
  - addi 0xFFF00093 → 0xFFFFFFFFFFFFFFFF.
  - slli x1,x1,32 (0x02009093) → 0x20, illegal 0.
  - The same word at XLEN=32 → illegal 1, err_cnt 1.
- Reset asserted with out_valid=1 and out_ready=0 → next cycle out_valid 0, imm 0, fmt 0, err_cnt 0, in_ready 1.
